// File: rtl/wisc_pkg.sv
// Shared encodings for the WISC pipeline: ALU opcodes, branch condition codes,
// flag bit positions and the branch-resolver state type.
package wisc_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;

   typedef enum logic [2:0] {
      CC_NEQ    = 3'b000,
      CC_EQ     = 3'b001,
      CC_GT     = 3'b010,
      CC_LT     = 3'b011,
      CC_GTE    = 3'b100,
      CC_LTE    = 3'b101,
      CC_OVFL   = 3'b110,
      CC_UNCOND = 3'b111
   } cond_t;

   localparam int FLG_Z = 2;
   localparam int FLG_V = 1;
   localparam int FLG_N = 0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/flag_unit_cond_eval.sv
// Combinational branch-condition evaluator: {Z,V,N} flags and a 3-bit code
// in, taken out. Shared with the decode stage.
import wisc_pkg::*;

module cond_eval #(
   parameter int FLAG_W = 3
) (
   input  logic [FLAG_W-1:0] flags,
   input  logic [2:0]        cond,
   output logic              taken
);

   // Condition decode against the supplied flags
   always_comb begin
      taken = 1'b0;
      case (cond_t'(cond))
         CC_NEQ:    taken = ~flags[FLG_Z];
         CC_EQ:     taken = flags[FLG_Z];
         CC_GT:     taken = ~flags[FLG_Z] & ~flags[FLG_N];
         CC_LT:     taken = flags[FLG_N];
         CC_GTE:    taken = flags[FLG_Z] | ~flags[FLG_N];
         CC_LTE:    taken = flags[FLG_Z] | flags[FLG_N];
         CC_OVFL:   taken = flags[FLG_V];
         CC_UNCOND: taken = 1'b1;
         default:   taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_unit.sv
// Condition-flag register with per-opcode write masks and a branch resolver.
// Define FLAG_BYPASS_EN to resolve hazard branches on forwarded flags (no WAIT).
import wisc_pkg::*;

module flag_unit #(
   parameter int FLAG_W = 3,
   parameter int OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [OP_W-1:0]   aluop,
   input  logic [FLAG_W-1:0] alu_flag,
   input  logic              stall,
   input  logic              flush,
   input  logic              br_valid,
   input  logic [2:0]        br_cond,
   output logic              br_ready,
   output logic              br_done,
   output logic              br_taken,
   output logic [FLAG_W-1:0] flag
);

   logic [FLAG_W-1:0] mask_s;
   logic [FLAG_W-1:0] wr_mask_s;
   logic [FLAG_W-1:0] merged_s;
   logic [FLAG_W-1:0] flag_r;
   logic [FLAG_W-1:0] eval_flag_s;
   logic [2:0]        eval_cond_s;
   logic [2:0]        cond_r;
   logic              eval_taken_s;
   logic              wr_en_s;
   logic              hazard_s;
   logic              ready_s;
   logic              accept_s;
   logic              taken_r;
   state_t            state_r;
   state_t            state_nxt_s;

   // Per-opcode flag update mask
   always_comb begin
      mask_s = {FLAG_W{1'b0}};
      case (aluop)
         OP_ADD, OP_SUB:                 mask_s = {FLAG_W{1'b1}};
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask_s[FLG_Z] = 1'b1;
         default:                        mask_s = {FLAG_W{1'b0}};
      endcase
   end

   assign wr_mask_s = alu_valid ? mask_s : {FLAG_W{1'b0}};
   assign merged_s  = (flag_r & ~wr_mask_s) | (alu_flag & wr_mask_s);
   assign wr_en_s   = alu_valid & ~stall & ~flush;
   assign hazard_s  = br_valid & (|wr_mask_s);
   assign accept_s  = br_valid & ready_s;

   // Architectural flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_r <= {FLAG_W{1'b0}};
      end else if (wr_en_s) begin
         flag_r <= merged_s;
      end
   end

   // Resolver state, latched condition and registered result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cond_r  <= 3'b000;
         taken_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            cond_r <= br_cond;
         end
         taken_r <= (state_nxt_s == DONE) ? eval_taken_s : 1'b0;
      end
   end

   // Next-state logic and selection of what gets evaluated
   always_comb begin
      state_nxt_s = state_r;
      eval_flag_s = flag_r;
      eval_cond_s = br_cond;
      case (state_r)
         IDLE, DONE: begin
            if (flush) begin
               state_nxt_s = IDLE;
            end else if (accept_s) begin
`ifdef FLAG_BYPASS_EN
               eval_flag_s = merged_s;
               state_nxt_s = DONE;
`else
               state_nxt_s = hazard_s ? WAIT : DONE;
`endif
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            eval_cond_s = cond_r;
            if (flush) begin
               state_nxt_s = IDLE;
            end else if (stall) begin
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Handshake output; the done/taken outputs come straight from registers
   always_comb begin
      ready_s = 1'b0;
      if (state_r != WAIT) begin
         ready_s = ~stall & ~flush;
      end else begin
         ready_s = 1'b0;
      end
   end

   cond_eval #(.FLAG_W(FLAG_W)) u_cond_eval (
      .flags (eval_flag_s),
      .cond  (eval_cond_s),
      .taken (eval_taken_s)
   );

   assign br_ready = ready_s;
   assign br_done  = (state_r == DONE);
   assign br_taken = taken_r;
   assign flag     = flag_r;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios then random traffic,
// all checked against a cycle-level behavioural model.
module tb_flag_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       alu_valid = 1'b0;
   logic [3:0] aluop = 4'b0000;
   logic [2:0] alu_flag = 3'b000;
   logic       stall = 1'b0;
   logic       flush = 1'b0;
   logic       br_valid = 1'b0;
   logic [2:0] br_cond = 3'b000;
   logic       br_ready, br_done, br_taken;
   logic [2:0] flag;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   logic [2:0] m_flag = 3'b000;
   bit         m_wait = 1'b0;
   logic [2:0] m_cond = 3'b000;

   flag_unit #(.FLAG_W(3), .OP_W(4)) dut (
      .clk(clk), .rst(rst), .alu_valid(alu_valid), .aluop(aluop),
      .alu_flag(alu_flag), .stall(stall), .flush(flush),
      .br_valid(br_valid), .br_cond(br_cond), .br_ready(br_ready),
      .br_done(br_done), .br_taken(br_taken), .flag(flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [2:0] ref_mask(input logic [3:0] op);
      if (op == 4'd0 || op == 4'd1) return 3'b111;
      if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 3'b100;
      return 3'b000;
   endfunction

   function automatic bit ref_taken(input logic [2:0] f, input logic [2:0] c);
      bit z, v, n;
      z = f[2]; v = f[1]; n = f[0];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || !n;
         3'd5: return z || n;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   // One clock of stimulus; entered and left at posedge+1
   task automatic step(input logic av, input logic [3:0] op, input logic [2:0] af,
                       input logic st, input logic fl, input logic bv, input logic [2:0] bc);
      bit         exp_ready, acc, haz, nd, nt;
      logic [2:0] mask, new_flag;
      alu_valid = av; aluop = op; alu_flag = af;
      stall = st; flush = fl; br_valid = bv; br_cond = bc;
      #1;
      exp_ready = !fl && !st && !m_wait;
      chk("br_ready", {31'd0, br_ready}, {31'd0, exp_ready});
      mask = ref_mask(op);
      acc  = bv && exp_ready;
      haz  = acc && av && (mask != 3'b000);
      nd = 1'b0; nt = 1'b0;
      new_flag = m_flag;
      if (av && !st && !fl) new_flag = (m_flag & ~mask) | (af & mask);
      if (m_wait) begin
         if (fl) m_wait = 1'b0;
         else if (!st) begin
            nd = 1'b1; nt = ref_taken(m_flag, m_cond); m_wait = 1'b0;
         end
      end else if (acc) begin
`ifdef FLAG_BYPASS_EN
         nd = 1'b1; nt = ref_taken(new_flag, bc);
`else
         if (haz) begin
            m_wait = 1'b1; m_cond = bc;
         end else begin
            nd = 1'b1; nt = ref_taken(m_flag, bc);
         end
`endif
      end
      m_flag = new_flag;
      @(posedge clk); #1;
      chk("flag", {29'd0, flag}, {29'd0, m_flag});
      chk("br_done", {31'd0, br_done}, {31'd0, nd});
      if (nd) chk("br_taken", {31'd0, br_taken}, {31'd0, nt});
   endtask

   task automatic idle();
      step(1'b0, 4'd3, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0);
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_flag", {29'd0, flag}, 32'd0);
      chk("rst_done", {31'd0, br_done}, 32'd0);
      chk("rst_taken", {31'd0, br_taken}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ready", {31'd0, br_ready}, 32'd1);

      // masked flag writes
      step(1'b1, 4'd0, 3'b101, 1'b0, 1'b0, 1'b0, 3'd0);
      chk("add_flag", {29'd0, flag}, 32'h5);
      step(1'b1, 4'd2, 3'b011, 1'b0, 1'b0, 1'b0, 3'd0);
      chk("xor_flag", {29'd0, flag}, 32'h1);

      // plain branches on flag = 001
      step(1'b0, 4'd3, 3'b000, 1'b0, 1'b0, 1'b1, 3'd3);
      chk("lt_done", {31'd0, br_done}, 32'd1);
      chk("lt_taken", {31'd0, br_taken}, 32'd1);
      step(1'b0, 4'd3, 3'b000, 1'b0, 1'b0, 1'b1, 3'd2);
      chk("gt_taken", {31'd0, br_taken}, 32'd0);
      idle();

      // hazard: SUB with branch EQ in the same cycle
      step(1'b1, 4'd1, 3'b100, 1'b0, 1'b0, 1'b1, 3'd1);
`ifdef FLAG_BYPASS_EN
      chk("byp_done", {31'd0, br_done}, 32'd1);
      chk("byp_taken", {31'd0, br_taken}, 32'd1);
      idle();
`else
      chk("haz_wait_done", {31'd0, br_done}, 32'd0);
      idle();
      chk("haz_done", {31'd0, br_done}, 32'd1);
      chk("haz_taken", {31'd0, br_taken}, 32'd1);
`endif

      // non-writing opcodes, then OVFL on 000
      step(1'b1, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0);
      step(1'b1, 4'd7, 3'b111, 1'b0, 1'b0, 1'b0, 3'd0);
      step(1'b1, 4'd8, 3'b111, 1'b0, 1'b0, 1'b0, 3'd0);
      chk("nowrite_flag", {29'd0, flag}, 32'h0);
      step(1'b0, 4'd3, 3'b000, 1'b0, 1'b0, 1'b1, 3'd6);
      chk("ovfl_taken", {31'd0, br_taken}, 32'd0);
      idle();

      // hazard branch, then flush in the WAIT cycle
      step(1'b1, 4'd0, 3'b100, 1'b0, 1'b0, 1'b1, 3'd1);
      step(1'b0, 4'd3, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0);
      chk("flush_nodone", {31'd0, br_done}, 32'd0);
      idle();

      // stall for three cycles with a live ADD and a branch request
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'd0, 3'b011, 1'b1, 1'b0, 1'b1, 3'd7);
         chk("stall_flag", {29'd0, flag}, 32'h4);
      end
      idle();

      // async reset during WAIT
      step(1'b1, 4'd0, 3'b010, 1'b0, 1'b0, 1'b1, 3'd6);
      alu_valid = 1'b0; br_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_flag", {29'd0, flag}, 32'd0);
      chk("arst_done", {31'd0, br_done}, 32'd0);
      chk("arst_ready", {31'd0, br_ready}, 32'd1);
      rst = 1'b0;
      m_flag = 3'b000; m_wait = 1'b0;
      @(posedge clk); #1;
      chk("arst_nodone", {31'd0, br_done}, 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
              4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)),
              ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0,
              3'($urandom_range(0, 7)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
